// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface div_if;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    modport master (
        output div_valid, div_signed, div_src1, div_src2, cancel,
        input  div_ready, busy, done, quotient, remainder
    );

    modport slave (
        input  div_valid, div_signed, div_src1, div_src2, cancel,
        output div_ready, busy, done, quotient, remainder
    );
endinterface

// File: rtl/div_sequencer.sv
// Iterative 32-bit restoring divider (DIV/DIVU): magnitudes in, one quotient bit
// per cycle, sign fix-up on the final iteration, cancel on pipeline flush.
module div_sequencer (
    input  logic   clk,
    input  logic   reset,
    div_if.slave   dif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [63:0] work;
    logic [31:0] dvsr;
    logic [31:0] src1_orig;
    logic        q_neg, r_neg, dz;

    logic [31:0] mag1, mag2;
    logic [33:0] trial;
    logic [63:0] work_nxt;
    logic [31:0] q_res, r_res;

    always_comb begin
        mag1 = (dif.div_signed && dif.div_src1[31]) ? -dif.div_src1 : dif.div_src1;
        mag2 = (dif.div_signed && dif.div_src2[31]) ? -dif.div_src2 : dif.div_src2;
        // Partial remainder after the shift is at most 33 bits; one extra bit holds the sign.
        trial    = {1'b0, work[63:31]} - {2'b0, dvsr};
        work_nxt = trial[33] ? {work[62:0], 1'b0} : {trial[31:0], work[30:0], 1'b1};
        q_res    = q_neg ? -work_nxt[31:0]  : work_nxt[31:0];
        r_res    = r_neg ? -work_nxt[63:32] : work_nxt[63:32];
        // Divide by zero still runs all iterations but reports fixed values.
        if (dz) begin
            q_res = 32'hFFFF_FFFF;
            r_res = src1_orig;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 5'd0;
            work          <= 64'd0;
            dvsr          <= 32'd0;
            src1_orig     <= 32'd0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            dz            <= 1'b0;
            dif.quotient  <= 32'd0;
            dif.remainder <= 32'd0;
        end else begin
            case (state)
                IDLE: if (dif.div_valid && !dif.cancel) begin
                    work      <= {32'd0, mag1};
                    dvsr      <= mag2;
                    src1_orig <= dif.div_src1;
                    q_neg     <= dif.div_signed & (dif.div_src1[31] ^ dif.div_src2[31]);
                    r_neg     <= dif.div_signed & dif.div_src1[31];
                    dz        <= (dif.div_src2 == 32'd0);
                    cnt       <= 5'd0;
                    state     <= CALC;
                end
                CALC: if (dif.cancel) begin
                    state <= IDLE;
                end else begin
                    work <= work_nxt;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state         <= DONE;
                        dif.quotient  <= q_res;
                        dif.remainder <= r_res;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dif.div_ready = (state == IDLE);
    assign dif.busy      = (state != IDLE);
    assign dif.done      = (state == DONE);
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, sign quadrants, corners, cancel, back-to-back, reset.
module tb_div_sequencer;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    div_if bus ();

    div_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .dif   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Issue one request, wait for done, check latency and results.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int n;
        int busy_n;
        n = 0;
        while (!bus.div_ready && n < 50) begin tick(); n++; end
        chk({name, " ready"}, {31'd0, bus.div_ready}, 32'd1);
        bus.div_signed = sgn;
        bus.div_src1   = a;
        bus.div_src2   = b;
        bus.div_valid  = 1'b1;
        tick();
        bus.div_valid = 1'b0;
        bus.div_src1  = 32'hDEAD_BEEF;
        bus.div_src2  = 32'h0000_0003;
        busy_n = bus.busy ? 1 : 0;
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
            if (bus.busy) busy_n++;
        end
        chk({name, " latency"}, n, 32);
        chk({name, " busy cycles"}, busy_n, 33);
        chk({name, " quotient"}, bus.quotient, eq);
        chk({name, " remainder"}, bus.remainder, er);
        tick();
        chk({name, " done pulse"}, {30'd0, bus.done, bus.div_ready}, 32'd1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset flags", {29'd0, bus.div_ready, bus.busy, bus.done}, 32'b100);
        chk("reset quotient", bus.quotient, 32'd0);
        chk("reset remainder", bus.remainder, 32'd0);
    endtask

    task automatic test_unsigned();
        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    endtask

    task automatic test_signed();
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("div -7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    endtask

    task automatic test_corner();
        run_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("divu big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    endtask

    task automatic test_div_zero();
        run_div("div /0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
        run_div("divu /0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
        run_div("div neg/0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    endtask

    task automatic test_cancel();
        int seen_done;
        // Cancel while idle blocks acceptance.
        bus.div_signed = 1'b0;
        bus.div_src1   = 32'd9;
        bus.div_src2   = 32'd3;
        bus.div_valid  = 1'b1;
        bus.cancel     = 1'b1;
        tick();
        bus.div_valid = 1'b0;
        bus.cancel    = 1'b0;
        chk("cancel idle blocks", {31'd0, bus.busy}, 32'd0);
        // Cancel mid-calculation.
        bus.div_valid = 1'b1;
        tick();
        bus.div_valid = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done) seen_done++;
        end
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cancel flags", {29'd0, bus.div_ready, bus.busy, bus.done}, 32'b100);
        chk("cancel no done", seen_done, 0);
        chk("cancel quotient kept", bus.quotient, 32'hFFFF_FFFF);
        chk("cancel remainder kept", bus.remainder, 32'hFFFF_FFF9);
        tick();
        run_div("after cancel 45/6", 1'b0, 32'd45, 32'd6, 32'd7, 32'd3);
    endtask

    task automatic test_back_to_back();
        int acc_t[$];
        logic [31:0] qs[$];
        logic [31:0] rs[$];
        logic prev_busy;
        prev_busy      = bus.busy;
        bus.div_signed = 1'b0;
        bus.div_src1   = 32'd50;
        bus.div_src2   = 32'd7;
        bus.div_valid  = 1'b1;
        for (int i = 0; i < 68; i++) begin
            tick();
            if (bus.busy && !prev_busy) begin
                acc_t.push_back(i);
                if (acc_t.size() == 1) begin
                    bus.div_src1 = 32'd1000;
                    bus.div_src2 = 32'd9;
                end
            end
            if (bus.done) begin
                qs.push_back(bus.quotient);
                rs.push_back(bus.remainder);
            end
            prev_busy = bus.busy;
        end
        bus.div_valid = 1'b0;
        chk("b2b acceptances", acc_t.size(), 2);
        chk("b2b done count", qs.size(), 2);
        if (acc_t.size() == 2) chk("b2b spacing", acc_t[1] - acc_t[0], 34);
        if (qs.size() == 2) begin
            chk("b2b q0", qs[0], 32'd7);
            chk("b2b r0", rs[0], 32'd1);
            chk("b2b q1", qs[1], 32'd111);
            chk("b2b r1", rs[1], 32'd1);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        int n;
        n = 0;
        while (!bus.div_ready && n < 50) begin tick(); n++; end
        bus.div_signed = 1'b0;
        bus.div_src1   = 32'd77;
        bus.div_src2   = 32'd5;
        bus.div_valid  = 1'b1;
        tick();
        bus.div_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset flags", {29'd0, bus.div_ready, bus.busy, bus.done}, 32'b100);
        chk("midreset quotient", bus.quotient, 32'd0);
        chk("midreset remainder", bus.remainder, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) seen_done++;
        end
        chk("midreset no done", seen_done, 0);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        bus.div_valid  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_src1   = 32'd0;
        bus.div_src2   = 32'd0;
        bus.cancel     = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_corner();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
